// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the canonical NOP and the base opcodes
// that decode logic keys on.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    function automatic logic [6:0] opcode_of(input logic [31:0] i_word);
        return i_word[6:0];
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch-address register: holds the address being requested and, on load, advances
// to the sequential successor or a word-aligned redirect target.
module pc_reg #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_branch_taken,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    input  logic [ADDR_WIDTH-1:0] i_cur_pc,
    output logic [ADDR_WIDTH-1:0] o_fetch_pc
);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_next_pc;

    // The low two target bits are dropped here; flagging them is the caller's job.
    always_comb begin
        w_next_pc = i_branch_taken ? (i_branch_target & ~ADDR_WIDTH'(3))
                                   : i_cur_pc + ADDR_WIDTH'(4);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (i_load) begin
            r_fetch_pc <= w_next_pc;
        end
    end

    assign o_fetch_pc = r_fetch_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests one word at a time from instruction memory,
// presents it to decode with a valid/ready handshake and applies redirects on accept.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  misalign,
    output logic [31:0]           fetch_count
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic                  w_capture;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_fetch_pc;

    logic                  r_imem_req;
    logic                  r_instr_valid;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_misalign;
    logic [31:0]           r_fetch_count;

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_load          (w_accept),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_cur_pc        (r_pc),
        .o_fetch_pc      (w_fetch_pc)
    );

    // NOTE: defaults first so no path through the case leaves a signal unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            BOOT: w_state_next = REQ;
            REQ: begin
                if (imem_ready) begin
                    w_capture    = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = REQ;
                end
            end
            default: w_state_next = BOOT;
        endcase
    end

    // Handshake outputs are registered from the next state so no input reaches a port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_pc          <= RESET_PC;
            r_misalign    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_imem_req    <= (w_state_next == REQ);
            r_instr_valid <= (w_state_next == HOLD);
            if (w_capture) begin
                r_instr <= imem_rdata;
                r_pc    <= w_fetch_pc;
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
                if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = w_fetch_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign misalign    = r_misalign;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory model with programmable wait states, directed
// stimulus and a scoreboard of expected (pc, instr) pairs checked on each accept.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        misalign;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   tests      = 0;
    int   errors     = 0;
    int   mem_wait   = 0;
    bit   idle_ready = 1'b1;

    instr_fetch #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .misalign      (misalign),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is its address XOR a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] w);
        exp_t e;
        e.pc    = p;
        e.instr = w;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},      {31'd0, imem_req},    32'd0);
        check({tag, "_addr"},     imem_addr,            32'h0);
        check({tag, "_valid"},    {31'd0, instr_valid}, 32'd0);
        check({tag, "_pc"},       pc,                   32'h0);
        check({tag, "_instr"},    instr,                32'h0000_0013);
        check({tag, "_misalign"}, {31'd0, misalign},    32'd0);
        check({tag, "_count"},    fetch_count,          32'd0);
    endtask

    // Memory model: answers after mem_wait request cycles; optionally drives a stray
    // ready with junk data while no request is outstanding.
    initial begin
        int cnt;
        cnt        = 0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                imem_ready = (cnt >= mem_wait);
                imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;
                cnt++;
            end else begin
                cnt        = 0;
                imem_ready = idle_ready;
                imem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Scoreboard monitor: every accepted instruction must match the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %h instr %h expected no accept", pc, instr);
                end else begin
                    e = sb.pop_front();
                    check("sb_pc", pc, e.pc);
                    check("sb_instr", instr, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Sequential fetch, decode always ready.
        instr_ready = 1'b1;
        push(32'h0, 32'h1234_0013);
        push(32'h4, 32'h1234_0017);
        push(32'h8, 32'h1234_001B);
        push(32'hC, 32'h1234_001F);

        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("boot_req",   {31'd0, imem_req},    32'd0);
        check("boot_valid", {31'd0, instr_valid}, 32'd0);

        step();  // cycle 2: first request
        check("c2_req",   {31'd0, imem_req},    32'd1);
        check("c2_addr",  imem_addr,            32'h0);
        check("c2_valid", {31'd0, instr_valid}, 32'd0);

        step();  // cycle 3: first instruction valid
        check("c3_valid", {31'd0, instr_valid}, 32'd1);
        check("c3_pc",    pc,                   32'h0);
        check("c3_instr", instr,                32'h1234_0013);

        repeat (7) step();
        check("seq_count", fetch_count,         32'd4);
        check("seq_addr",  imem_addr,           32'h10);
        check("seq_req",   {31'd0, imem_req},   32'd1);

        // Five wait states on the fetch at 0x10.
        instr_ready = 1'b0;
        mem_wait    = 5;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait_addr",  imem_addr,            32'h10);
            check("wait_req",   {31'd0, imem_req},    32'd1);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        step();
        check("wait_done_valid", {31'd0, instr_valid}, 32'd1);
        check("wait_done_pc",    pc,                   32'h10);
        check("wait_done_instr", instr,                32'h1234_0003);
        check("wait_done_req",   {31'd0, imem_req},    32'd0);

        // Backpressure with a stray misaligned redirect that must be ignored.
        branch_taken  = 1'b1;
        branch_target = 32'h201;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid",    {31'd0, instr_valid}, 32'd1);
            check("hold_pc",       pc,                   32'h10);
            check("hold_instr",    instr,                32'h1234_0003);
            check("hold_req",      {31'd0, imem_req},    32'd0);
            check("hold_misalign", {31'd0, misalign},    32'd0);
        end

        push(32'h10, 32'h1234_0003);
        instr_ready   = 1'b1;
        branch_target = 32'h40;
        mem_wait      = 0;
        step();
        check("redir_addr",     imem_addr,          32'h40);
        check("redir_req",      {31'd0, imem_req},  32'd1);
        check("redir_count",    fetch_count,        32'd5);
        check("redir_misalign", {31'd0, misalign},  32'd0);

        instr_ready   = 1'b0;
        branch_target = 32'h80;  // branch still high outside accept: no effect
        step();
        check("redir_valid", {31'd0, instr_valid}, 32'd1);
        check("redir_pc",    pc,                   32'h40);
        check("redir_instr", instr,                32'h1234_0053);

        // Misaligned redirect to 0x43.
        push(32'h40, 32'h1234_0053);
        instr_ready   = 1'b1;
        branch_target = 32'h43;
        step();
        check("mis_addr",     imem_addr,         32'h40);
        check("mis_flag",     {31'd0, misalign}, 32'd1);
        check("mis_count",    fetch_count,       32'd6);

        push(32'h40, 32'h1234_0053);
        branch_target = 32'hFFFF_FFFC;
        repeat (2) step();
        check("top_addr",     imem_addr,         32'hFFFF_FFFC);
        check("top_misalign", {31'd0, misalign}, 32'd1);
        check("top_count",    fetch_count,       32'd7);

        // Sequential wrap from the top of the address space.
        push(32'hFFFF_FFFC, 32'hEDCB_FFEF);
        branch_taken = 1'b0;
        repeat (2) step();
        check("wrap_addr",     imem_addr,         32'h0);
        check("wrap_count",    fetch_count,       32'd8);
        check("wrap_misalign", {31'd0, misalign}, 32'd1);

        push(32'h0, 32'h1234_0013);
        repeat (2) step();
        check("pre_rst_addr",  imem_addr,         32'h4);
        check("pre_rst_count", fetch_count,       32'd9);
        check("pre_rst_req",   {31'd0, imem_req}, 32'd1);

        // Reset in REQ while memory answers in the same cycle.
        instr_ready = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        check("inrst_req",   {31'd0, imem_req},    32'd0);
        check("inrst_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("reboot_req", {31'd0, imem_req}, 32'd0);
        step();
        check("reboot_req2",  {31'd0, imem_req},    32'd1);
        check("reboot_addr",  imem_addr,            32'h0);
        check("reboot_valid", {31'd0, instr_valid}, 32'd0);

        push(32'h0, 32'h1234_0013);
        instr_ready = 1'b1;
        step();
        check("refetch_valid", {31'd0, instr_valid}, 32'd1);
        check("refetch_pc",    pc,                   32'h0);
        check("refetch_instr", instr,                32'h1234_0013);
        step();
        check("refetch_count", fetch_count, 32'd1);
        check("refetch_addr",  imem_addr,   32'h4);

        instr_ready = 1'b0;
        repeat (3) step();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: ADDR_WIDTH, 32, width of PC and memory address.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_WIDTH  word-aligned fetch address.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction to the control unit and register-file decode.
- instr_valid  out  1  instr and pc are valid.
- instr_ready  in  1  decode accepts instr this cycle.
- pc  out  ADDR_WIDTH  address of instr.
- branch_taken  in  1  redirect (PCsrc), sampled only on the accept cycle.
- branch_target  in  ADDR_WIDTH  redirect address (PC + ImmOp).
- misalign  out  1  sticky flag: a redirect target had bits [1:0] != 0.
- fetch_count  out  32  number of accepted instructions.

Function
REQ-004 FSM states: BOOT, REQ, HOLD.
REQ-005 BOOT: a single cycle after reset release; imem_req=0; next state REQ.
REQ-006 REQ: imem_req=1 and imem_addr=fetch_pc, both held stable until imem_ready.
- imem_ready=1: capture imem_rdata into instr and fetch_pc into pc; next state HOLD.
REQ-007 REQ: imem_ready=0 for any number of cycles → stay in REQ; no timeout.
REQ-008 HOLD: instr_valid=1, imem_req=0; instr and pc held stable until instr_ready=1.
REQ-009 HOLD with instr_ready=1 (accept):
- fetch_pc ← branch_taken ? {branch_target[ADDR_WIDTH-1:2],2'b00} : pc+4.
- Next state REQ.
- fetch_count increments.
REQ-010 branch_taken and branch_target are ignored in every cycle other than the accept cycle.
REQ-011 Redirect with branch_target[1:0] != 0 on the accept cycle:
- misalign set, and it stays set until reset.
- The redirect still proceeds to the aligned address.
REQ-012 pc+4 wraps modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC → 32'h0000_0000.
REQ-013 fetch_count wraps modulo 2^32.
REQ-014 Latency:
- Minimum imem_req-to-instr_valid is 1 cycle (imem_ready on the first REQ cycle).
- Accept-to-next-imem_req is 1 cycle.
- Maximum throughput is 1 instruction per 2 cycles.
REQ-015 instr_valid=0 in BOOT and REQ; instr_ready has no effect when instr_valid=0.
REQ-016 imem_ready asserted outside REQ is ignored.
REQ-017 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-018 rst_n=0 asynchronously forces the following, in any state including mid-request:
- state=BOOT, fetch_pc=RESET_PC.
- pc=RESET_PC, instr=32'h0000_0013 (NOP).
- instr_valid=0, imem_req=0, imem_addr=RESET_PC.
- misalign=0, fetch_count=0.
REQ-019 A memory response that arrives during or after reset for a pre-reset request is discarded (imem_ready is ignored in BOOT).

Structure
REQ-020 Shared package cpu_pkg holds:
- the fetch state enum;
- the NOP encoding 32'h0000_0013;
- the opcode constants (OP_IMM 7'b0010011, BRANCH 7'b1100011, STORE 7'b0100011, LOAD 7'b0000011).
REQ-021 One sub-module: pc_reg (PC register with RESET_PC, load enable and next-PC mux); the FSM and counters live in instr_fetch.

Verification
REQ-022 Reset release with imem_ready tied 1: imem_req is 1 in cycle 2 with imem_addr=0; instr_valid is 1 in cycle 3 with pc=0; instr=imem_rdata.
REQ-023 Sequential fetch with instr_ready=1 and no branch: accepted pc sequence is 0, 4, 8, 12; fetch_count=4 after the fourth accept.
REQ-024 Wait states: imem_ready held 0 for 5 cycles → imem_addr stable and instr_valid=0 throughout; data returned on the 6th cycle appears valid on the next cycle.
REQ-025 Backpressure and redirect:
- HOLD with instr_ready=0 for 3 cycles → instr/pc stable, no new imem_req.
- Then accept with branch_taken=1, branch_target=32'h40 → next imem_addr=32'h40.
- branch_taken=1 asserted outside the accept cycle has no effect.
REQ-026 Misaligned redirect and wrap:
- branch_target=32'h43 → imem_addr=32'h40 and misalign=1, sticky.
- Fetch at 32'hFFFF_FFFC accepted with no branch → next imem_addr=32'h0.
REQ-027 rst_n asserted in REQ with imem_ready=1 in the same cycle → all outputs at reset values immediately; after release, the first fetch is RESET_PC.
